// File: rtl/c432_ctrl_pkg.sv
// c432_ctrl_pkg: shared widths, FSM state encoding and core output bit-order
// indices for the c432 key/query sequencer.
package c432_ctrl_pkg;

   localparam int DEF_KEY_W      = 32;
   localparam int DEF_PI_W       = 36;
   localparam int DEF_PO_W       = 7;
   localparam int DEF_SETTLE_CYC = 2;
   localparam int BEAT_CNT_W     = 6;

   // Position of each core output net inside the captured PO vector
   localparam int PO_G223 = 0;
   localparam int PO_G329 = 1;
   localparam int PO_G370 = 2;
   localparam int PO_G421 = 3;
   localparam int PO_G430 = 4;
   localparam int PO_G431 = 5;
   localparam int PO_G432 = 6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHIFT  = 3'd1,
      ST_CHECK  = 3'd2,
      ST_APPLY  = 3'd3,
      ST_SETTLE = 3'd4,
      ST_RESP   = 3'd5
   } ctrl_state_t;

endpackage

// File: rtl/c432_key_ctrl_if.sv
// c432_key_ctrl_if: host-side key stream, query and result handshakes.
// The master modport is the SAT-simulator host; the slave modport is the controller.
interface c432_key_ctrl_if
   import c432_ctrl_pkg::*;
#(
   parameter int PI_W = DEF_PI_W,
   parameter int PO_W = DEF_PO_W
);

   logic            key_bit_i;
   logic            key_valid_i;
   logic            key_last_i;
   logic            key_ready_o;
   logic            key_loaded_o;
   logic            key_err_o;
   logic            q_valid_i;
   logic [PI_W-1:0] q_pi_i;
   logic            q_ready_o;
   logic            r_valid_o;
   logic [PO_W-1:0] r_po_o;
   logic            r_ready_i;

   modport master (
      output key_bit_i, key_valid_i, key_last_i, q_valid_i, q_pi_i, r_ready_i,
      input  key_ready_o, key_loaded_o, key_err_o, q_ready_o, r_valid_o, r_po_o
   );

   modport slave (
      input  key_bit_i, key_valid_i, key_last_i, q_valid_i, q_pi_i, r_ready_i,
      output key_ready_o, key_loaded_o, key_err_o, q_ready_o, r_valid_o, r_po_o
   );

endinterface

// File: rtl/c432_key_shreg.sv
// c432_key_shreg: shadow key shift register, beat counter and frame check.
// C432_KEY_PARITY_EN adds a trailing even-parity beat to every key frame.
module c432_key_shreg
   import c432_ctrl_pkg::*;
#(
   parameter int KEY_W = DEF_KEY_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             beat,
   input  logic             bit_in,
   output logic [KEY_W-1:0] shadow,
   output logic             frame_ok
);

`ifdef C432_KEY_PARITY_EN
   localparam int FRAME_LEN = KEY_W + 1;
`else
   localparam int FRAME_LEN = KEY_W;
`endif

   localparam logic [BEAT_CNT_W-1:0] KEY_BEATS  = BEAT_CNT_W'(KEY_W);
   localparam logic [BEAT_CNT_W-1:0] FRAME_BEATS = BEAT_CNT_W'(FRAME_LEN);

   logic [BEAT_CNT_W-1:0] beat_cnt;
   logic                  overrun;
   logic                  parity_ok;

   // Key bits arrive LSB first, so each new bit enters at the top and the
   // first bit ends up in bit 0 after KEY_W shifts. Beats past the frame
   // length are dropped and only remembered as an overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow   <= '0;
         beat_cnt <= '0;
         overrun  <= 1'b0;
      end else if (start) begin
         shadow   <= {bit_in, shadow[KEY_W-1:1]};
         beat_cnt <= BEAT_CNT_W'(1);
         overrun  <= 1'b0;
      end else if (beat) begin
         if (beat_cnt < KEY_BEATS) begin
            shadow   <= {bit_in, shadow[KEY_W-1:1]};
            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
         end else if (beat_cnt < FRAME_BEATS) begin
            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
         end else begin
            overrun  <= 1'b1;
         end
      end
   end

`ifdef C432_KEY_PARITY_EN
   logic par_bit;

   // The beat following the last key bit carries even parity over the key
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bit <= 1'b0;
      end else if (start) begin
         par_bit <= 1'b0;
      end else if (beat && (beat_cnt == KEY_BEATS)) begin
         par_bit <= bit_in;
      end
   end

   assign parity_ok = (par_bit == ^shadow);
`else
   assign parity_ok = 1'b1;
`endif

   assign frame_ok = (beat_cnt == FRAME_BEATS) && !overrun && parity_ok;

endmodule

// File: rtl/c432_key_ctrl.sv
// c432_key_ctrl: serial key loader and query sequencer in front of the locked c432 core.
// Key frame parity is optional via C432_KEY_PARITY_EN (handled in c432_key_shreg).
module c432_key_ctrl
   import c432_ctrl_pkg::*;
#(
   parameter int KEY_W      = DEF_KEY_W,
   parameter int PI_W       = DEF_PI_W,
   parameter int PO_W       = DEF_PO_W,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
)
(
   input  logic             clk,
   input  logic             rst_n,
   c432_key_ctrl_if.slave   host,
   output logic [KEY_W-1:0] core_key_o,
   output logic [PI_W-1:0]  core_pi_o,
   input  logic [PO_W-1:0]  core_po_i
);

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);

   ctrl_state_t      state;
   ctrl_state_t      state_nxt;
   logic [3:0]       settle_cnt;
   logic             settle_done;
   logic [KEY_W-1:0] shadow;
   logic             frame_ok;
   logic             key_ready;
   logic             q_ready;
   logic             r_valid;
   logic             key_loaded;
   logic             key_err;
   logic [PO_W-1:0]  r_po;
   logic             start_beat;
   logic             shift_beat;
   logic             q_hs;

   assign start_beat  = (state == ST_IDLE) && host.key_valid_i;
   assign shift_beat  = (state == ST_SHIFT) && host.key_valid_i;
   assign q_hs        = q_ready && host.q_valid_i;
   assign settle_done = (state == ST_SETTLE) && (settle_cnt == 4'd1);

   c432_key_shreg #(.KEY_W(KEY_W)) u_shreg (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_beat),
      .beat     (shift_beat),
      .bit_in   (host.key_bit_i),
      .shadow   (shadow),
      .frame_ok (frame_ok)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a key beat in IDLE takes priority over a pending query
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (host.key_valid_i) begin
               state_nxt = host.key_last_i ? ST_CHECK : ST_SHIFT;
            end else if (q_hs) begin
               state_nxt = ST_APPLY;
            end
         end
         ST_SHIFT: begin
            if (host.key_valid_i && host.key_last_i) begin
               state_nxt = ST_CHECK;
            end
         end
         ST_CHECK:  state_nxt = ST_IDLE;
         ST_APPLY:  state_nxt = ST_SETTLE;
         ST_SETTLE: begin
            if (settle_done) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (host.r_ready_i) begin
               state_nxt = ST_IDLE;
            end
         end
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs are pure functions of the state plus the key-priority rule
   always_comb begin
      key_ready = 1'b0;
      q_ready   = 1'b0;
      r_valid   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            key_ready = 1'b1;
            q_ready   = key_loaded && !host.key_valid_i;
         end
         ST_SHIFT:  key_ready = 1'b1;
         ST_RESP:   r_valid   = 1'b1;
         default: begin
            key_ready = 1'b0;
            q_ready   = 1'b0;
            r_valid   = 1'b0;
         end
      endcase
   end

   // The core key only moves at the CHECK edge, so it can never change under a query
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_key_o <= '0;
         key_loaded <= 1'b0;
         key_err    <= 1'b0;
      end else if (state == ST_CHECK) begin
         if (frame_ok) begin
            core_key_o <= shadow;
            key_loaded <= 1'b1;
         end else begin
            key_err    <= 1'b1;
         end
      end else if (start_beat) begin
         key_err <= 1'b0;
      end
   end

   // Settle counter holds the number of SETTLE cycles still to run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
      end else if (state == ST_APPLY) begin
         settle_cnt <= SETTLE_INIT;
      end else if (state == ST_SETTLE) begin
         settle_cnt <= settle_cnt - 4'd1;
      end
   end

   // Stimulus is registered on the query handshake and never cleared afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_pi_o <= '0;
         r_po      <= '0;
      end else begin
         if (q_hs && !host.key_valid_i) begin
            core_pi_o <= host.q_pi_i;
         end
         if (settle_done) begin
            r_po <= core_po_i;
         end
      end
   end

   assign host.key_ready_o  = key_ready;
   assign host.key_loaded_o = key_loaded;
   assign host.key_err_o    = key_err;
   assign host.q_ready_o    = q_ready;
   assign host.r_valid_o    = r_valid;
   assign host.r_po_o       = r_po;

endmodule

// File: tb/tb_c432_key_ctrl.sv
// tb_c432_key_ctrl: directed self-checking bench for the c432 key/query sequencer.
// Builds with or without C432_KEY_PARITY_EN; frame length and parity beat follow the macro.
module tb_c432_key_ctrl;
   import c432_ctrl_pkg::*;

`ifdef C432_KEY_PARITY_EN
   localparam int FRAME_BEATS = 33;
`else
   localparam int FRAME_BEATS = 32;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] coreKey;
   logic [35:0] corePi;
   logic [6:0]  corePo;

   int numChecks;
   int numFails;
   int hsCount;
   int firstHs;
   int secondHs;

   c432_key_ctrl_if #(.PI_W(36), .PO_W(7)) ifc ();

   c432_key_ctrl #(
      .KEY_W      (32),
      .PI_W       (36),
      .PO_W       (7),
      .SETTLE_CYC (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .host       (ifc.slave),
      .core_key_o (coreKey),
      .core_pi_o  (corePi),
      .core_po_i  (corePo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      numChecks++;
      if (got !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic bitVal, input logic last);
      ifc.key_valid_i = valid;
      ifc.key_bit_i   = bitVal;
      ifc.key_last_i  = last;
   endtask

   // Returns with the last beat taken, i.e. the controller sits in CHECK
   task automatic sendFrame(input logic [31:0] key, input int nBeats, input bit probeQuery,
                            input bit badParity);
      logic bitVal;
      for (int i = 0; i < nBeats; i++) begin
         if (i < 32) bitVal = key[i];
         else        bitVal = (^key) ^ badParity;
         applyStimulus(1'b1, bitVal, (i == nBeats - 1));
         if (probeQuery && i == 0) begin
            #1;
            checkOutput("collQReady", ifc.q_ready_o, 1'b0);
            checkOutput("collKReady", ifc.key_ready_o, 1'b1);
         end
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkResetValues(input string phase);
      checkOutput({phase, "KeyReady"}, ifc.key_ready_o, 1'b1);
      checkOutput({phase, "QReady"}, ifc.q_ready_o, 1'b0);
      checkOutput({phase, "Loaded"}, ifc.key_loaded_o, 1'b0);
      checkOutput({phase, "Err"}, ifc.key_err_o, 1'b0);
      checkOutput({phase, "RValid"}, ifc.r_valid_o, 1'b0);
      checkOutput({phase, "CoreKey"}, coreKey, 32'h0);
      checkOutput({phase, "CorePi"}, corePi, 36'h0);
      checkOutput({phase, "RPo"}, ifc.r_po_o, 7'h0);
   endtask

   initial begin
      numChecks = 0;
      numFails  = 0;
      rst_n     = 1'b0;
      corePo    = 7'h00;
      applyStimulus(1'b0, 1'b0, 1'b0);
      ifc.q_valid_i = 1'b0;
      ifc.q_pi_i    = '0;
      ifc.r_ready_i = 1'b0;

      #3;
      checkResetValues("rst");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Good key: commit lands one edge after the last beat
      sendFrame(32'hA5A5_0F0F, FRAME_BEATS, 1'b0, 1'b0);
      checkOutput("preCommitKey", coreKey, 32'h0);
      checkOutput("preCommitLoaded", ifc.key_loaded_o, 1'b0);
      checkOutput("checkQReady", ifc.q_ready_o, 1'b0);
      tick();
      checkOutput("goodKey", coreKey, 32'hA5A5_0F0F);
      checkOutput("goodLoaded", ifc.key_loaded_o, 1'b1);
      checkOutput("goodErr", ifc.key_err_o, 1'b0);
      checkOutput("goodQReady", ifc.q_ready_o, 1'b1);

      // Short frame: last on beat 20
      sendFrame(32'h1234_5678, 20, 1'b0, 1'b0);
      tick();
      checkOutput("shortErr", ifc.key_err_o, 1'b1);
      checkOutput("shortKey", coreKey, 32'hA5A5_0F0F);
      checkOutput("shortLoaded", ifc.key_loaded_o, 1'b1);

      // Overlong frame: 40 beats, last only on the final one
      sendFrame(32'hFFFF_FFFF, 40, 1'b0, 1'b0);
      tick();
      checkOutput("longErr", ifc.key_err_o, 1'b1);
      checkOutput("longKey", coreKey, 32'hA5A5_0F0F);

`ifdef C432_KEY_PARITY_EN
      sendFrame(32'h0000_0001, FRAME_BEATS, 1'b0, 1'b1);
      tick();
      checkOutput("parityErr", ifc.key_err_o, 1'b1);
      checkOutput("parityKey", coreKey, 32'hA5A5_0F0F);
`endif

      // Re-load a good key, which also clears the sticky error
      sendFrame(32'hA5A5_0F0F, FRAME_BEATS, 1'b0, 1'b0);
      tick();
      checkOutput("reloadErr", ifc.key_err_o, 1'b0);

      // Query latency: valid three edges after the handshake edge
      corePo        = 7'h55;
      ifc.q_valid_i = 1'b1;
      ifc.q_pi_i    = 36'hF_FFFF_FFFF;
      #1;
      checkOutput("qReadyIdle", ifc.q_ready_o, 1'b1);
      tick();
      ifc.q_valid_i = 1'b0;
      checkOutput("applyPi", corePi, 36'hF_FFFF_FFFF);
      checkOutput("latE0", ifc.r_valid_o, 1'b0);
      tick();
      checkOutput("latE1", ifc.r_valid_o, 1'b0);
      tick();
      checkOutput("latE2", ifc.r_valid_o, 1'b0);
      tick();
      checkOutput("latE3", ifc.r_valid_o, 1'b1);
      checkOutput("latPo", ifc.r_po_o, 7'h55);

      // Backpressure: result held while the core output wanders
      ifc.q_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         corePo = 7'(i * 13 + 1);
         tick();
         checkOutput("bpPo", ifc.r_po_o, 7'h55);
         checkOutput("bpQReady", ifc.q_ready_o, 1'b0);
         checkOutput("bpKReady", ifc.key_ready_o, 1'b0);
         checkOutput("bpValid", ifc.r_valid_o, 1'b1);
      end
      ifc.q_valid_i = 1'b0;
      ifc.r_ready_i = 1'b1;
      tick();
      checkOutput("bpRelease", ifc.r_valid_o, 1'b0);
      checkOutput("bpPiHeld", corePi, 36'hF_FFFF_FFFF);

      // Back-to-back queries with r_ready tied high: one per five cycles
      corePo        = 7'h2A;
      ifc.q_pi_i    = 36'h1_2345_6789;
      ifc.q_valid_i = 1'b1;
      hsCount  = 0;
      firstHs  = 0;
      secondHs = 0;
      for (int cyc = 0; cyc < 30 && hsCount < 2; cyc++) begin
         if (ifc.q_ready_o && ifc.q_valid_i) begin
            if (hsCount == 0) firstHs = cyc;
            else              secondHs = cyc;
            hsCount++;
         end
         tick();
      end
      ifc.q_valid_i = 1'b0;
      checkOutput("thruCount", hsCount, 2);
      checkOutput("thruGap", secondHs - firstHs, 5);
      tick();
      tick();
      tick();
      checkOutput("thruValid", ifc.r_valid_o, 1'b1);
      checkOutput("thruPo", ifc.r_po_o, 7'h2A);
      tick();
      ifc.r_ready_i = 1'b0;
      checkOutput("thruIdle", ifc.q_ready_o, 1'b1);

      // Collision: key beat and query in the same IDLE cycle
      corePo        = 7'h13;
      ifc.q_pi_i    = 36'hA_5A5A_5A5A;
      ifc.q_valid_i = 1'b1;
      sendFrame(32'h3C3C_1234, FRAME_BEATS, 1'b1, 1'b0);
      checkOutput("collPiHeld", corePi, 36'h1_2345_6789);
      tick();
      checkOutput("collKey", coreKey, 32'h3C3C_1234);
      checkOutput("collQReadyAfter", ifc.q_ready_o, 1'b1);
      tick();
      ifc.q_valid_i = 1'b0;
      checkOutput("collPi", corePi, 36'hA_5A5A_5A5A);
      tick();
      tick();
      tick();
      checkOutput("collValid", ifc.r_valid_o, 1'b1);
      checkOutput("collPo", ifc.r_po_o, 7'h13);
      checkOutput("collKeyStable", coreKey, 32'h3C3C_1234);
      ifc.r_ready_i = 1'b1;
      tick();
      ifc.r_ready_i = 1'b0;

      // Reset in the middle of SETTLE discards key and result
      corePo        = 7'h7F;
      ifc.q_pi_i    = 36'h0_0000_0F0F;
      ifc.q_valid_i = 1'b1;
      tick();
      ifc.q_valid_i = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      checkResetValues("midRst");
      #2;
      rst_n = 1'b1;
      tick();
      checkOutput("postRstQReady", ifc.q_ready_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
